// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: MMIO map, FSM encoding and status packing shared by the dmem responder.
package dmem_responder_pkg;
    localparam int         MMIO_SEL_BIT = 31;
    localparam logic [1:0] MMIO_TXDATA  = 2'd0;
    localparam logic [1:0] MMIO_STATUS  = 2'd1;
    localparam logic [1:0] MMIO_CYCLES  = 2'd2;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    function automatic logic [31:0] status_word(input logic ovf, input logic full, input logic empty);
        return {29'b0, ovf, full, empty};
    endfunction
endpackage

// File: rtl/dmem_responder_tx_fifo.sv
// dmem_responder_tx_fifo: circular TX queue; a push into a full queue is dropped unless a pop frees a slot.
module dmem_responder_tx_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_push,
    input  logic [31:0] i_data,
    input  logic        i_ready,
    output logic [31:0] o_data,
    output logic        o_valid,
    output logic        o_full,
    output logic        o_empty,
    output logic        o_drop
);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [PW:0]  r_wr, r_rd;
    logic [31:0]  r_mem [FIFO_DEPTH];
    logic         w_pop, w_accept;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_empty  = r_wr == r_rd;
    assign o_full   = (r_wr[PW] != r_rd[PW]) && (r_wr[PW-1:0] == r_rd[PW-1:0]);
    assign w_pop    = i_ready & ~o_empty;
    assign w_accept = i_push & (~o_full | w_pop);
    assign o_drop   = i_push & o_full & ~w_pop;
    assign o_valid  = ~o_empty;
    assign o_data   = o_empty ? '0 : r_mem[r_rd[PW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            r_wr <= r_wr + {{PW{1'b0}}, w_accept};
            r_rd <= r_rd + {{PW{1'b0}}, w_pop};
        end
    end

    always_ff @(posedge clock) begin
        if (w_accept)
            r_mem[r_wr[PW-1:0]] <= i_data;
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data RAM plus MMIO page (TX queue, status, cycle counter) behind the dmem port.
// The RAM is zeroed word by word after reset; init_done gates every access.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        init_done
);
    localparam int DEPTH = 2 ** ADDR_W;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_idx;
    logic [31:0]         r_mem [DEPTH];
    logic [31:0]         r_cycle_cnt, r_q, w_rd;
    logic                r_overflow;
    logic                w_ready, w_mmio, w_ram_wr, w_push, w_status_clr;
    logic                w_full, w_empty, w_drop, w_unused;
    logic [1:0]          w_reg;
    logic [ADDR_W-1:0]   w_addr;

    assign w_ready      = r_state == ST_READY;
    assign w_mmio       = address_dmem[MMIO_SEL_BIT];
    assign w_reg        = address_dmem[1:0];
    assign w_addr       = address_dmem[ADDR_W-1:0];
    assign w_ram_wr     = w_ready & wren & ~w_mmio;
    assign w_push       = w_ready & wren & w_mmio & (w_reg == MMIO_TXDATA);
    assign w_status_clr = w_ready & wren & w_mmio & (w_reg == MMIO_STATUS);
    assign w_unused     = ^address_dmem[30:ADDR_W];
    assign init_done    = w_ready;
    assign q_dmem       = r_q;

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_CLEAR && &r_clr_idx)
            w_state_nxt = ST_READY;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_CLEAR;
            r_clr_idx   <= '0;
            r_cycle_cnt <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_clr_idx   <= w_ready ? r_clr_idx : r_clr_idx + ADDR_W'(1);
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            // An overflowing push wins over a same-cycle status clear.
            r_overflow  <= w_drop | (r_overflow & ~w_status_clr);
        end
    end

    always_ff @(posedge clock) begin
        if (!w_ready)
            r_mem[r_clr_idx] <= '0;
        else if (w_ram_wr)
            r_mem[w_addr] <= data;
    end

    always_comb begin
        w_rd = !w_ready                ? '0 :
               !w_mmio                 ? r_mem[w_addr] :
               w_reg == MMIO_STATUS    ? status_word(r_overflow, w_full, w_empty) :
               w_reg == MMIO_CYCLES    ? r_cycle_cnt : '0;
    end

    // Loads land on the falling edge so the processor's next rising-edge capture sees them.
    always_ff @(negedge clock or negedge reset) begin
        if (!reset)
            r_q <= '0;
        else
            r_q <= w_rd;
    end

    dmem_responder_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (data),
        .i_ready (tx_ready),
        .o_data  (tx_data),
        .o_valid (tx_valid),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_drop  (w_drop)
    );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized stimulus against a queue/array reference model; a monitor drains the scoreboard.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int FD    = 8;
    localparam int K_Q = 0, K_INIT = 1, K_TXV = 2, K_HEAD = 3;
    localparam logic [31:0] IDLE = 32'h8000_0003;
    localparam logic [31:0] TXD  = {1'b1, 29'b0, MMIO_TXDATA};
    localparam logic [31:0] STS  = {1'b1, 29'b0, MMIO_STATUS};
    localparam logic [31:0] CYC  = {1'b1, 29'b0, MMIO_CYCLES};

    logic        clock = 1'b0, reset = 1'b0;
    logic [31:0] address_dmem = IDLE, data = '0, q_dmem, tx_data;
    logic        wren = 1'b0, tx_ready = 1'b0, tx_valid, init_done;

    always #5 clock = ~clock;

    dmem_responder #(.ADDR_W(AW), .FIFO_DEPTH(FD)) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .init_done    (init_done)
    );

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       nm;
    } exp_t;

    exp_t        sb[$];
    int          total = 0, bad = 0, force_cnt = 0;
    logic        rd_en = 1'b0;
    string       tag = "";

    logic [31:0] m_ram [DEPTH];
    logic [31:0] m_txq[$];
    logic [31:0] m_cyc;
    bit          m_ovf;
    int          m_edges, seen_force = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic we, input logic rd, input string nm);
        address_dmem = a;
        data         = d;
        wren         = we;
        rd_en        = rd;
        tag          = nm;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(IDLE, 0, 1'b0, 1'b0, "");
    endtask

    // Reference model: sees the inputs the next rising edge will use, predicts this half-cycle's outputs, then applies that edge.
    initial forever begin : model
        logic [31:0] a, ev;
        bit ready, ovf_set, clr;
        @(negedge clock);
        #1;
        if (!reset) begin
            m_edges = 0;
            m_cyc   = 0;
            m_ovf   = 0;
            m_txq.delete();
        end else begin
            if (force_cnt != seen_force) begin
                seen_force = force_cnt;
                m_cyc = 32'hFFFF_FFFF;
            end
            ready = m_edges >= DEPTH;
            a = address_dmem;
            sb.push_back('{K_INIT, {31'b0, ready}, "init_done"});
            sb.push_back('{K_TXV, {31'b0, m_txq.size() > 0}, "tx_valid"});
            if (m_txq.size() > 0)
                sb.push_back('{K_HEAD, m_txq[0], "tx_head"});
            if (rd_en) begin
                if (!ready)                   ev = 0;
                else if (!a[31])              ev = m_ram[a[AW-1:0]];
                else if (a[1:0] == 2'd1)      ev = {29'b0, m_ovf, m_txq.size() == FD, m_txq.size() == 0};
                else if (a[1:0] == 2'd2)      ev = m_cyc;
                else                          ev = 0;
                sb.push_back('{K_Q, ev, tag});
            end
            if (m_txq.size() > 0 && tx_ready)
                void'(m_txq.pop_front());
            ovf_set = 0;
            clr     = 0;
            if (ready && wren) begin
                if (!a[31])                   m_ram[a[AW-1:0]] = data;
                else if (a[1:0] == 2'd0) begin
                    if (m_txq.size() < FD)    m_txq.push_back(data);
                    else                      ovf_set = 1;
                end else if (a[1:0] == 2'd1)  clr = 1;
            end
            m_ovf = ovf_set ? 1'b1 : (clr ? 1'b0 : m_ovf);
            m_cyc = m_cyc + 1;
            m_edges++;
            if (m_edges == DEPTH)
                foreach (m_ram[i]) m_ram[i] = 0;
        end
    end

    initial forever begin : monitor
        exp_t e;
        @(negedge clock);
        #2;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_Q:     chk(e.nm, q_dmem, e.exp);
                K_INIT:  chk(e.nm, {31'b0, init_done}, e.exp);
                K_TXV:   chk(e.nm, {31'b0, tx_valid}, e.exp);
                default: chk(e.nm, tx_data, e.exp);
            endcase
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: no finish by time limit");
        $fatal(1);
    end

    task automatic reset_checks(input string nm);
        chk({nm, "_q"}, q_dmem, 0);
        chk({nm, "_txv"}, {31'b0, tx_valid}, 0);
        chk({nm, "_txd"}, tx_data, 0);
        chk({nm, "_init"}, {31'b0, init_done}, 0);
    endtask

    task automatic clear_and_scan(input string nm);
        for (int i = 0; i < DEPTH; i++) step(32'd3, 32'h1234, 1'b1, 1'b1, {nm, "_clr_rd3"});
        for (int i = 0; i < DEPTH; i++) step(i, 0, 1'b0, 1'b1, {nm, "_zero"});
    endtask

    initial begin
        logic [31:0] r, c0, c1;
        repeat (2) @(posedge clock);
        #1;
        reset_checks("por");
        reset = 1'b1;
        clear_and_scan("init");

        step(32'd5, 32'hDEAD_BEEF, 1'b1, 1'b0, "");
        step(32'd5, 0, 1'b0, 1'b1, "ld5");
        step(32'h1005, 0, 1'b0, 1'b1, "ld_alias");
        repeat (60) begin
            r = $urandom();
            step({1'b0, r[30:0]}, $urandom(), r[31], ~r[31], "ram_rand");
        end

        tx_ready = 1'b0;
        for (int v = 1; v <= 8; v++) step(TXD, v, 1'b1, 1'b0, "");
        step(STS, 0, 1'b0, 1'b1, "sts_full");
        step(TXD, 9, 1'b1, 1'b0, "");
        step(STS, 0, 1'b0, 1'b1, "sts_ovf");
        tx_ready = 1'b1;
        idle(10);
        step(STS, 0, 1'b0, 1'b1, "sts_drained");
        step(STS, 0, 1'b1, 1'b0, "");
        step(STS, 0, 1'b0, 1'b1, "sts_cleared");

        tx_ready = 1'b0;
        for (int v = 1; v <= 8; v++) step(TXD, v, 1'b1, 1'b0, "");
        tx_ready = 1'b1;
        step(TXD, 32'hA, 1'b1, 1'b0, "");
        tx_ready = 1'b0;
        chk("head_after_pushpop", tx_data, 2);
        step(STS, 0, 1'b0, 1'b1, "sts_pushpop_full");
        tx_ready = 1'b1;
        idle(10);

        repeat (100) begin
            r = $urandom();
            tx_ready = (r[3:2] == 2'd0);
            case (r[1:0])
                2'd0, 2'd1: step({1'b1, r[30:4], 2'b0, MMIO_TXDATA}, $urandom(), 1'b1, 1'b0, "");
                2'd2:       step({1'b1, r[30:4], 2'b0, MMIO_STATUS}, $urandom(), r[5], ~r[5], "sts_rand");
                default:    step({1'b1, r[30:4], 2'b0, MMIO_CYCLES}, 0, r[5], 1'b1, "cyc_rand");
            endcase
        end
        tx_ready = 1'b1;
        idle(10);
        tx_ready = 1'b0;

        step(CYC, 0, 1'b0, 1'b1, "cyc_a");
        c0 = q_dmem;
        idle(9);
        step(CYC, 0, 1'b0, 1'b1, "cyc_b");
        c1 = q_dmem;
        chk("cyc_diff", c1 - c0, 10);

        force dut.r_cycle_cnt = 32'hFFFF_FFFF;
        force_cnt++;
        #1;
        release dut.r_cycle_cnt;
        step(CYC, 0, 1'b0, 1'b1, "cyc_max");
        step(CYC, 0, 1'b0, 1'b1, "cyc_wrap");

        for (int v = 1; v <= 3; v++) step(TXD, 32'h100 + v, 1'b1, 1'b0, "");
        reset = 1'b0;
        #1;
        reset_checks("rst_queue");
        idle(2);
        reset = 1'b1;
        repeat (5) step(32'd3, 32'h55, 1'b1, 1'b1, "mid_clr_rd3");
        reset = 1'b0;
        #1;
        reset_checks("rst_clear");
        idle(1);
        reset = 1'b1;
        clear_and_scan("reinit");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
